// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton conditioner: synchroniser, debounce, edge pulses and
// an optional auto-repeat press per channel. All outputs are registered.
//
// Auto-repeat FSM (one per channel):
//   state  | meaning
//   IDLE   | no repeat pending; armed only by a rise while repeat_en is high
//   DELAY  | button held, counting REPEAT_DELAY cycles to the first repeat press
//   REPEAT | button held, emitting a press every REPEAT_PERIOD cycles
module btn_conditioner #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 10000000,
  parameter int REPEAT_PERIOD   = 2000000
) (
  input  logic            clk_20,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] press
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] RD_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RP_LAST = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [DW-1:0]          dcnt_q [N_CH];
  logic [DW-1:0]          dcnt_d [N_CH];
  logic [HW-1:0]          hcnt_q [N_CH];
  logic [HW-1:0]          hcnt_d [N_CH];
  rep_state_e             state_q [N_CH];
  rep_state_e             state_d [N_CH];

  logic [N_CH-1:0] s;
  logic [N_CH-1:0] level_d;
  logic [N_CH-1:0] flip_up;
  logic [N_CH-1:0] flip_dn;
  logic [N_CH-1:0] rep_pulse;

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      s[i]       = sync_q[i][SYNC_STAGES-1];
      level_d[i] = level[i];
      dcnt_d[i]  = '0;
      flip_up[i] = 1'b0;
      flip_dn[i] = 1'b0;
      if (s[i] != level[i]) begin
        if (dcnt_q[i] == DC_LAST) begin
          level_d[i] = ~level[i];
          flip_up[i] = ~level[i];
          flip_dn[i] = level[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]   = state_q[i];
      hcnt_d[i]    = hcnt_q[i];
      rep_pulse[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          hcnt_d[i] = '0;
          if (flip_up[i] && repeat_en[i]) state_d[i] = DELAY;
        end
        DELAY: begin
          if (flip_dn[i] || !repeat_en[i]) begin
            state_d[i] = IDLE;
            hcnt_d[i]  = '0;
          end else if (hcnt_q[i] == RD_LAST) begin
            rep_pulse[i] = 1'b1;
            hcnt_d[i]    = '0;
            state_d[i]   = REPEAT;
          end else begin
            hcnt_d[i] = hcnt_q[i] + HW'(1);
          end
        end
        REPEAT: begin
          if (flip_dn[i] || !repeat_en[i]) begin
            state_d[i] = IDLE;
            hcnt_d[i]  = '0;
          end else if (hcnt_q[i] == RP_LAST) begin
            rep_pulse[i] = 1'b1;
            hcnt_d[i]    = '0;
          end else begin
            hcnt_d[i] = hcnt_q[i] + HW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          hcnt_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_20) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        hcnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_20) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= '0;
        dcnt_q[i] <= '0;
      end
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      press <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn[i]};
        dcnt_q[i] <= dcnt_d[i];
      end
      level <= level_d;
      rise  <= flip_up;
      fall  <= flip_dn;
      press <= flip_up | rep_pulse;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: vector table, directed multi-cycle sequences and
// randomized traffic, all checked against a window/arithmetic reference model.
module tb_btn_conditioner;

  localparam int N  = 2;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk_20 = 1'b0;
  logic         rst;
  logic [N-1:0] btn, repeat_en;
  logic [N-1:0] level, rise, fall, press;

  always #5 clk_20 = ~clk_20;

  btn_conditioner #(
    .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_20(clk_20), .rst(rst), .btn(btn), .repeat_en(repeat_en),
    .level(level), .rise(rise), .fall(fall), .press(press)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: btn delayed S edges, level flips when the last D samples
  // all disagree with it; repeats are timed by age since the rise.
  logic [N-1:0] bq[$];
  logic [N-1:0] sq[$];
  logic [N-1:0] m_level, m_rise, m_fall, m_press;
  bit           armed[N];
  int           age[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    repeat (S) bq.push_back('0);
    sq.delete();
    repeat (D) sq.push_back('0);
    m_level = '0; m_rise = '0; m_fall = '0; m_press = '0;
    for (int c = 0; c < N; c++) begin
      armed[c] = 1'b0;
      age[c]   = 0;
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] b, input logic [N-1:0] e);
    logic [N-1:0] smp;
    bit all_diff;
    m_rise = '0; m_fall = '0; m_press = '0;
    if (r) begin
      model_reset();
      return;
    end
    smp = bq.pop_front();
    bq.push_back(b);
    void'(sq.pop_front());
    sq.push_back(smp);
    for (int c = 0; c < N; c++) begin
      all_diff = 1'b1;
      foreach (sq[k]) if (sq[k][c] == m_level[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[c] = ~m_level[c];
        if (m_level[c]) begin
          m_rise[c] = 1'b1; m_press[c] = 1'b1; armed[c] = e[c]; age[c] = 0;
        end else begin
          m_fall[c] = 1'b1; armed[c] = 1'b0;
        end
      end else if (m_level[c] && armed[c]) begin
        age[c]++;
        if (!e[c]) armed[c] = 1'b0;
        else if (age[c] >= RD && (age[c] - RD) % RP == 0) m_press[c] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] b, input logic [N-1:0] e, input string name);
    @(negedge clk_20);
    rst = r; btn = b; repeat_en = e;
    @(posedge clk_20);
    model_step(r, b, e);
    #1;
    chk(name, {level, rise, fall, press}, {m_level, m_rise, m_fall, m_press});
  endtask

  task automatic wait_rise(input logic [N-1:0] b, input logic [N-1:0] e, input string name);
    int found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      step(1'b0, b, e, "model_wait");
      if (rise[0]) found = 1;
    end
    chk(name, found, 1);
  endtask

  typedef struct {
    logic       r;
    logic [1:0] b;
    logic [1:0] e;
    int         reps;
    logic [1:0] lv, ri, fa, pr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] map;
    int n, idx;
    logic [N-1:0] rb, re;
    logic rr;

    rst = 1'b1; btn = '0; repeat_en = '0;
    model_reset();

    // reset with buttons held, then release; then a clean ch0 press/release
    tbl.push_back('{1'b1, 2'b11, 2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b11});
    tbl.push_back('{1'b0, 2'b11, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 5, 2'b11, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b11, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 2'b00, 1, 2'b01, 2'b01, 2'b00, 2'b01});
    tbl.push_back('{1'b0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 5, 2'b01, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00});

    foreach (tbl[v]) begin
      for (int k = 0; k < tbl[v].reps; k++) begin
        step(tbl[v].r, tbl[v].b, tbl[v].e, "model_tbl");
        chk("tbl_vec", {level, rise, fall, press},
            {tbl[v].lv, tbl[v].ri, tbl[v].fa, tbl[v].pr});
      end
    end

    // bounce: runs of 3 never reach level, then one rise on the hold
    map = '0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, {1'b0, logic'((c / 3) % 2 == 0)}, 2'b00, "model_bounce");
      map[0] = map[0] | level[0] | rise[0] | fall[0] | press[0];
    end
    chk("bounce_quiet", map, 0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 2'b01, 2'b00, "model_hold");
      if (rise[0]) n++;
    end
    chk("bounce_one_rise", n, 1);
    repeat (10) step(1'b0, 2'b00, 2'b00, "model_rel");

    // auto-repeat while held
    wait_rise(2'b01, 2'b01, "rep_rise_timeout");
    map = '0;
    map[0] = press[0];
    for (int k = 1; k < 30; k++) begin
      step(1'b0, 2'b01, 2'b01, "model_rep");
      map[k] = press[0];
    end
    chk("repeat_map", map, (1 << 0) | (1 << 10) | (1 << 13) | (1 << 16) |
                           (1 << 19) | (1 << 22) | (1 << 25) | (1 << 28));
    n = 0;
    for (int k = 0; k < 12 && n == 0; k++) begin
      step(1'b0, 2'b00, 2'b01, "model_rep_rel");
      if (fall[0]) n = 1;
    end
    chk("repeat_fall", n, 1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 2'b00, 2'b01, "model_rep_idle");
      if (press[0]) n++;
    end
    chk("no_press_after_fall", n, 0);

    // enable drop at t+12, re-enable at t+15 while held
    wait_rise(2'b01, 2'b01, "drop_rise_timeout");
    map = '0;
    map[0] = press[0];
    for (int k = 1; k < 30; k++) begin
      step(1'b0, 2'b01, (k >= 13 && k < 16) ? 2'b00 : 2'b01, "model_drop");
      map[k] = press[0];
    end
    chk("endrop_map", map, (1 << 0) | (1 << 10));
    repeat (12) step(1'b0, 2'b00, 2'b01, "model_drop_rel");
    wait_rise(2'b01, 2'b01, "rearm_rise_timeout");
    repeat (10) step(1'b0, 2'b01, 2'b01, "model_rearm");
    chk("rearm_press", press[0], 1);
    repeat (12) step(1'b0, 2'b00, 2'b01, "model_rearm_rel");

    // reset mid-repeat at t+11 with the button still held
    wait_rise(2'b01, 2'b01, "rst_rise_timeout");
    for (int k = 1; k < 12; k++) step(1'b0, 2'b01, 2'b01, "model_prerst");
    step(1'b1, 2'b01, 2'b01, "model_rst");
    chk("rst_clear", {level, rise, fall, press}, 0);
    step(1'b1, 2'b01, 2'b01, "model_rst");
    idx = -1;
    for (int k = 0; k < 12 && idx < 0; k++) begin
      step(1'b0, 2'b01, 2'b01, "model_postrst");
      if (rise[0]) idx = k;
    end
    chk("rst_relatency", idx, 5);

    // randomized traffic against the model
    rb = 2'b01; re = 2'b01;
    for (int i = 0; i < 900; i++) begin
      int p;
      p = ((i / 150) % 2 == 1) ? 25 : 4;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(p - 1) == 0) rb[c] = ~rb[c];
        if ($urandom_range(29) == 0) re[c] = ~re[c];
      end
      rr = ($urandom_range(79) == 0);
      step(rr, rb, re, "model_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
